// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcodes, flag bit positions, FSM states and helpers for the ALU issue/retire stage.
package alu_op_sequencer_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_D = 3;

  localparam logic [DATA_W-1:0] DIV_ZERO_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DIV_START,
    DIV_WAIT,
    HOLD
  } state_t;

  function automatic logic [3:0] make_flags(input logic d, input logic c,
                                            input logic [DATA_W-1:0] r);
    logic [3:0] f;
    f        = '0;
    f[FLG_D] = d;
    f[FLG_C] = c;
    f[FLG_N] = r[DATA_W-1];
    f[FLG_Z] = (r == '0);
    return f;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_alu_comb_select.sv
// Combinational op mux over the add/sub/mul/compare/logic units; produces {carry, result}.
module alu_comb_select
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_carry,
  output logic [WIDTH-1:0] o_result
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_prod;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Two's-complement subtract; the carry-out is the unsigned no-borrow indication.
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_prod = i_a * i_b;

  always_comb begin
    o_carry  = 1'b0;
    o_result = '0;
    case (i_op)
      OP_ADD: {o_carry, o_result} = w_sum;
      OP_SUB: {o_carry, o_result} = w_diff;
      OP_MUL: o_result = w_prod;
      OP_CMP: begin
        if (i_a == i_b)           o_result = '0;
        else if (w_diff[WIDTH-1]) o_result = WIDTH'(1);
        else                      o_result = WIDTH'(2);
      end
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/retire stage: single-cycle ALU ops, multi-cycle divide via start/done, held result handshake.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIV_TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_result,
  output logic             busy
);

  localparam int TMO_W = $clog2(DIV_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_b;
  logic [TMO_W-1:0] r_tmo;
  logic             r_done_q;

  logic             w_accept;
  logic             w_done_rise;
  logic             w_alu_c;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_load_alu;
  logic             w_load_div;
  logic             w_load_err;
  logic             w_load_divres;

  alu_comb_select #(.WIDTH(WIDTH)) u_alu (
    .i_op     (in_op),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_carry  (w_alu_c),
    .o_result (w_alu_res)
  );

  // Gated by reset so decode never sees ready while the stage is held in reset.
  assign in_ready    = reset & ((r_state == IDLE) | ((r_state == HOLD) & out_ready));
  assign w_accept    = in_valid & in_ready;
  assign w_done_rise = div_done & ~r_done_q;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_alu    = 1'b0;
    w_load_div    = 1'b0;
    w_load_err    = 1'b0;
    w_load_divres = 1'b0;
    case (r_state)
      IDLE, HOLD: begin
        if (w_accept) begin
          if (in_op != OP_DIV) begin
            w_load_alu  = 1'b1;
            w_state_nxt = HOLD;
          end else if (in_b == '0) begin
            w_load_err  = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_load_div  = 1'b1;
            w_state_nxt = DIV_START;
          end
        end else if ((r_state == HOLD) && out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      DIV_START: w_state_nxt = DIV_WAIT;
      DIV_WAIT: begin
        if (w_done_rise) begin
          w_load_divres = 1'b1;
          w_state_nxt   = HOLD;
        end else if (r_tmo == TMO_W'(DIV_TIMEOUT)) begin
          w_load_err  = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
      r_flags  <= '0;
      r_div_a  <= '0;
      r_div_b  <= '0;
      r_tmo    <= '0;
      r_done_q <= 1'b0;
    end else begin
      // Sampled every cycle so a done level left high by the previous divide is never an edge.
      r_done_q <= div_done;
      if (w_load_alu) begin
        r_result <= w_alu_res;
        r_flags  <= make_flags(1'b0, w_alu_c, w_alu_res);
      end
      if (w_load_err) begin
        r_result <= DIV_ZERO_RESULT;
        r_flags  <= make_flags(1'b1, 1'b0, DIV_ZERO_RESULT);
      end
      if (w_load_divres) begin
        r_result <= div_result;
        r_flags  <= make_flags(1'b0, 1'b0, div_result);
      end
      if (w_load_div) begin
        r_div_a <= in_a;
        r_div_b <= in_b;
      end
      if (r_state == DIV_START)     r_tmo <= '0;
      else if (r_state == DIV_WAIT) r_tmo <= r_tmo + 1'b1;
    end
  end

  assign out_valid  = (r_state == HOLD);
  assign out_result = r_result;
  assign out_flags  = r_flags;
  assign div_start  = (r_state == DIV_START);
  assign div_a      = r_div_a;
  assign div_b      = r_div_b;
  assign busy       = (r_state == DIV_START) | (r_state == DIV_WAIT);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized checks of alu_op_sequencer against an arithmetic reference and a divider model.
module tb_alu_op_sequencer;

  localparam int TMO = 31;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic       div_start;
  logic [7:0] div_a;
  logic [7:0] div_b;
  logic       div_done;
  logic [7:0] div_result;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;

  alu_op_sequencer #(.WIDTH(8), .DIV_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .div_start  (div_start),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_done   (div_done),
    .div_result (div_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: done stays high after completion and only drops two cycles after a
  // new start, then rises 9 cycles after the start; result is garbage until then.
  logic       dv_hang;
  logic [3:0] dv_cnt;
  logic [7:0] dv_la;
  logic [7:0] dv_lb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_done   <= 1'b0;
      div_result <= 8'h00;
      dv_cnt     <= 4'd0;
      dv_la      <= 8'h00;
      dv_lb      <= 8'h00;
    end else if (div_start) begin
      div_result <= 8'hA5;
      dv_cnt     <= 4'd9;
      dv_la      <= div_a;
      dv_lb      <= div_b;
    end else if (dv_cnt != 4'd0) begin
      dv_cnt <= dv_cnt - 4'd1;
      if (dv_cnt == 4'd8) div_done <= 1'b0;
      if (dv_cnt == 4'd1 && !dv_hang) begin
        div_done   <= 1'b1;
        div_result <= (dv_lb == 8'h00) ? 8'hFF : dv_la / dv_lb;
      end
    end
  end

  always @(posedge clk) if (div_start) n_start <= n_start + 1;

  // Reference: {D,C,N,Z, result} from plain integer arithmetic.
  function automatic logic [11:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int unsigned ia, ib, r;
    logic c, d;
    logic [7:0] r8;
    ia = a; ib = b; c = 1'b0; d = 1'b0; r = 0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 255); end
      3'd1: begin r = ia + 256 - ib; c = (ia >= ib); end
      3'd2: r = ia * ib;
      3'd3: if (ib == 0) begin r = 255; d = 1'b1; end else r = ia / ib;
      3'd4: r = (ia == ib) ? 0 : (((ia + 256 - ib) % 256) >= 128 ? 1 : 2);
      3'd5: r = ia & ib;
      3'd6: r = ia | ib;
      default: r = ia ^ ib;
    endcase
    r8 = 8'(r % 256);
    return {d, c, r8[7], (r8 == 8'h00), r8};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int stall);
    logic [11:0] e;
    int w;
    e = ref_op(op, a, b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
    #1;
    check($sformatf("op%0d_ready", op), 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
    w = 0;
    while (!out_valid && w < 60) begin tick(); w++; end
    check($sformatf("op%0d_valid", op), 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    repeat (stall) tick();
    check($sformatf("op%0d_%0h_%0h_result", op, a, b), {20'h0, out_flags, out_result},
          {20'h0, e});
    out_ready = 1'b1;
    tick();
    check($sformatf("op%0d_retire", op), 32'(out_valid), 32'd0);
  endtask

  initial begin
    int s0, nb, stab, bad;
    rst_n = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 8'h00; in_b = 8'h00;
    out_ready = 1'b0; dv_hang = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_outs", {in_ready, out_valid, out_result, out_flags, div_start, div_a, div_b, busy},
          32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready), 32'd1);

    // DIV by zero: immediate error result, no divider start
    s0 = n_start;
    in_valid = 1'b1; in_op = 3'd3; in_a = 8'h2A; in_b = 8'h00; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    check("dz_out", {out_valid, out_flags, out_result}, {19'h0, 1'b1, 4'hA, 8'hFF});
    check("dz_nostart", 32'(n_start - s0), 32'd0);
    tick();
    check("dz_retire", 32'(out_valid), 32'd0);

    // ADD with carry-out
    in_valid = 1'b1; in_op = 3'd0; in_a = 8'hF0; in_b = 8'h20;
    tick(); in_valid = 1'b0;
    check("add_out", {out_valid, out_flags, out_result}, {19'h0, 1'b1, 4'h4, 8'h10});
    tick();
    check("add_idle", 32'(out_valid), 32'd0);

    // Back-to-back SUB then CMP with writeback always ready
    in_valid = 1'b1; in_op = 3'd1; in_a = 8'h05; in_b = 8'h07;
    tick();
    check("sub_out", {out_valid, out_flags, out_result}, {19'h0, 1'b1, 4'h2, 8'hFE});
    check("b2b_ready", 32'(in_ready), 32'd1);
    in_op = 3'd4; in_a = 8'h03; in_b = 8'h03;
    tick(); in_valid = 1'b0;
    check("cmp_out", {out_valid, out_flags, out_result}, {19'h0, 1'b1, 4'h1, 8'h00});
    tick();
    check("cmp_idle", 32'(out_valid), 32'd0);

    // First divide leaves done high for the next one
    run_op(3'd3, 8'hC8, 8'h05, 0);

    // DIV 64/07 against a stale-high done
    s0 = n_start; nb = 0; stab = 1;
    in_valid = 1'b1; in_op = 3'd3; in_a = 8'h64; in_b = 8'h07;
    tick();
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
    for (int i = 0; i < 60 && !out_valid; i++) begin
      if (busy) nb++;
      if (div_a !== 8'h64 || div_b !== 8'h07) stab = 0;
      tick();
    end
    check("div_out", {out_valid, out_flags, out_result}, {19'h0, 1'b1, 4'h0, 8'h0E});
    check("div_busy_cycles", 32'(nb), 32'd11);
    check("div_operands_stable", 32'(stab), 32'd1);
    check("div_one_start", 32'(n_start - s0), 32'd1);
    check("div_busy_off", 32'(busy), 32'd0);
    tick();
    check("div_idle", 32'(out_valid), 32'd0);

    // MUL held by writeback stall; next op waits
    in_valid = 1'b1; in_op = 3'd2; in_a = 8'h0C; in_b = 8'h0B; out_ready = 1'b0;
    tick();
    in_op = 3'd0; in_a = 8'h01; in_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mul_hold%0d", i), {out_valid, in_ready, out_flags, out_result},
            {18'h0, 2'b10, 4'h2, 8'h84});
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("mul_release_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    check("add2_out", {out_valid, out_flags, out_result}, {19'h0, 1'b1, 4'h0, 8'h02});
    tick();
    check("add2_idle", 32'(out_valid), 32'd0);

    // Divider never completes: timeout error
    dv_hang = 1'b1; nb = 0;
    in_valid = 1'b1; in_op = 3'd3; in_a = 8'h10; in_b = 8'h03;
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 80 && !out_valid; i++) begin
      if (busy) nb++;
      tick();
    end
    check("to_out", {out_valid, out_flags, out_result}, {19'h0, 1'b1, 4'hA, 8'hFF});
    check("to_latency", 32'(nb >= TMO && nb <= TMO + 3), 32'd1);
    tick();
    dv_hang = 1'b0;

    // Reset in the middle of DIV_WAIT
    in_valid = 1'b1; in_op = 3'd3; in_a = 8'h64; in_b = 8'h07;
    tick(); in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outs", {in_ready, out_valid, out_result, out_flags, div_start, div_a, div_b, busy},
          32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("post_reset_ready", 32'(in_ready), 32'd1);
    s0 = n_start; bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid || busy) bad++;
      tick();
    end
    check("post_reset_quiet", 32'(bad), 32'd0);
    check("post_reset_nostart", 32'(n_start - s0), 32'd0);

    // Randomized ops with random writeback stalls
    for (int k = 0; k < 40; k++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      run_op(op, a, b, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue/retire stage in front of the 8-bit ALU datapath.
- Accepts one operation per valid/ready handshake from decode.
- Single-cycle ops (add, sub, mul, compare, logic) go to the existing combinational units. DIV goes to the multi-cycle restoring divider through its start/done interface.
- Registers the result plus status flags and holds them on a valid/ready output handshake until writeback consumes them.

Parameters:
- WIDTH, 8, operand/result width; only 8 is supported by the attached units.
- DIV_TIMEOUT, 31, max cycles waited in DIV_WAIT before forcing an error completion.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous active-low reset; state clears immediately on reset low
- in_valid  in  1  decode presents an operation
- in_ready  out  1  sequencer accepts the operation this cycle
- in_op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 CMP, 101 AND, 110 OR, 111 XOR
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  result/flags are valid
- out_ready  in  1  writeback consumes the result
- out_result  out  WIDTH  registered result
- out_flags  out  4  {D,C,N,Z}: div error, carry-out, result[7], result==0
- div_start  out  1  one-cycle start pulse to the divider
- div_a  out  WIDTH  latched dividend, stable from DIV_START through DIV_WAIT
- div_b  out  WIDTH  latched divisor, same stability
- div_done  in  1  divider done level; stays high after completion
- div_result  in  WIDTH  divider quotient, sampled on the done rising edge
- busy  out  1  high in DIV_START/DIV_WAIT

Behaviour:
- Reset values: in_ready=0 while reset low, then 1 in IDLE. out_valid=0, out_result=0, out_flags=0, div_start=0, div_a=0, div_b=0, busy=0, state=IDLE, timeout counter=0, done_q=0.
- Accept: a transfer occurs when in_valid & in_ready.
  - in_ready=1 in IDLE.
  - in_ready=1 in HOLD only when out_ready=1 (back-to-back retire and accept).
  - in_ready=0 in DIV_START and DIV_WAIT.
- Single-cycle ops: the result is computed combinationally in the accept cycle and registered at that edge. State goes to HOLD; out_valid=1 on the next cycle (latency 1).
  - ADD: {C,result} = a+b.
  - SUB: result = a + (~b+1) mod 256; C = no-borrow (a>=b unsigned).
  - MUL: low 8 bits of the product; C=0.
  - CMP: result = 00 if a==b, 01 if (a-b)[7]=1, 02 otherwise (matches the 2-bit compare code, zero-extended); C=0.
  - AND/OR/XOR: bitwise; C=0.
- Flags: Z=(result==0), N=result[7], D=0 unless stated below.
- DIV, b!=0: latch div_a/div_b, go to DIV_START. In DIV_START, div_start=1 for exactly one cycle, then go to DIV_WAIT.
  - In DIV_WAIT, done_q registers div_done each cycle. Completion = div_done & ~done_q (rising edge only; a stale high done from a previous division is ignored).
  - On completion, register div_result and flags (C=0, D=0) and go to HOLD.
  - Timeout counter clears on entering DIV_WAIT and increments each cycle. At DIV_TIMEOUT: result=FF, D=1, go to HOLD.
- DIV, b==0: no divider start. Register result=FF, flags D=1, N=1, Z=0, C=0; HOLD next cycle (latency 1).
- HOLD: out_valid=1; out_result and out_flags stable.
  - out_ready=1 with no new accept: go to IDLE, out_valid=0 next cycle.
  - out_ready=1 with a new accept: the new op is processed as from IDLE in the same edge, so out_valid stays 1 for a single-cycle op, or drops for DIV.
  - out_ready=0: hold indefinitely.
- Reset mid-operation (any state): immediate return to reset values. An in-flight divide is abandoned; the divider shares reset and clears too. No partial result is ever presented.
- div_start never asserts outside DIV_START. in_* are ignored when no transfer occurs.

Decomposition:
- Shared package: opcode constants (OP_ADD..OP_XOR), flag bit indices (FLG_Z=0, FLG_N=1, FLG_C=2, FLG_D=3), state encoding (IDLE, DIV_START, DIV_WAIT, HOLD), DIV_ZERO_RESULT=8'hFF.
- One natural sub-module: alu_comb_select, the combinational op mux wrapping the existing adder, subtractor, multiplier and compare units and producing {C,result}.
- The FSM, timeout counter and done edge detect stay in the top.

Test Plan:
- Reset low mid-DIV_WAIT -> all outputs zero immediately; after release in_ready=1, div_start never pulses.
- ADD a=F0 b=20, out_ready=1 -> one cycle later out_valid=1, result=10, flags C=1 Z=0 N=0; next cycle IDLE.
- Back-to-back SUB 05-07 then CMP 03,03 with out_ready held 1 -> results FE (N=1, C=0) then 00 (Z=1) on consecutive cycles, out_valid continuous.
- DIV a=64 b=07 with model divider (done 9 cycles after start, stale done=1 beforehand) -> single div_start pulse, no early capture, result=0E, D=0, busy high until capture.
- DIV a=2A b=00 -> no div_start, result=FF, D=1, N=1, out_valid next cycle.
- MUL 0C*0B with out_ready=0 for 5 cycles -> result=84 N=1 held stable, in_ready=0; accepted when out_ready rises.
